// File: rtl/bus_timer_if.sv
// rtl/bus_timer_if.sv - APB-like register bus between the core and bus_timer
interface bus_timer_if;
  logic [31:0] addr;
  logic        select;
  logic        enable;
  logic        write;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        ready;

  modport master (
    output addr, select, enable, write, wdata,
    input  rdata, ready
  );

  modport slave (
    input  addr, select, enable, write, wdata,
    output rdata, ready
  );
endinterface

// File: rtl/bus_timer.sv
// rtl/bus_timer.sv - machine timer: 64-bit mtime with prescaler, mtimecmp, ctrl, level irq
module bus_timer #(
  parameter int WAIT_CYCLES    = 0,
  parameter int PRESCALE_WIDTH = 8
) (
  input  logic       clk,
  input  logic       rst,
  bus_timer_if.slave bus,
  output logic       irqTimer
);

  localparam logic [3:0] WAIT_INIT = 4'(WAIT_CYCLES);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1
  } state_t;

  state_t                    state_q;
  logic [3:0]                wait_cnt_q;
  logic [2:0]                off_q;
  logic                      wr_q;
  logic [31:0]               wdata_q;

  logic [63:0]               mtime_q;
  logic [63:0]               mtimecmp_q;
  logic                      run_q;
  logic                      irq_en_q;
  logic [PRESCALE_WIDTH-1:0] div_q;
  logic [PRESCALE_WIDTH-1:0] pcnt_q;
  logic [31:0]               shadow_q;
  logic                      irq_q;

  logic                      completion;
  logic                      do_write;
  logic                      do_read_lo;
  logic                      tick;
  logic [63:0]               mtime_ticked;
  logic                      mtime_ge;
  logic [31:0]               ctrl_rd;
  logic [31:0]               rd_val;
  logic                      unused_addr;

  assign unused_addr = ^{bus.addr[31:5], bus.addr[1:0]};

  // The setup phase is captured on the IDLE->WAIT edge so that, with no wait
  // states, the first access-phase cycle is already the completion cycle.
  assign completion   = (state_q == WAIT) && bus.select && bus.enable && (wait_cnt_q == 4'd0);
  assign do_write     = completion && wr_q;
  assign do_read_lo   = completion && !wr_q && (off_q == 3'd0);

  assign tick         = run_q && (pcnt_q == div_q);
  assign mtime_ticked = mtime_q + 64'(tick);
  assign mtime_ge     = (mtime_q >= mtimecmp_q);

  always_comb begin
    ctrl_rd                         = '0;
    ctrl_rd[0]                      = run_q;
    ctrl_rd[1]                      = irq_en_q;
    ctrl_rd[8 +: PRESCALE_WIDTH]    = div_q;
  end

  always_comb begin
    rd_val = '0;
    case (off_q)
      3'd0:    rd_val = mtime_q[31:0];
      3'd1:    rd_val = shadow_q;
      3'd2:    rd_val = mtimecmp_q[31:0];
      3'd3:    rd_val = mtimecmp_q[63:32];
      3'd4:    rd_val = ctrl_rd;
      3'd5:    rd_val = {31'd0, mtime_ge};
      default: rd_val = '0;
    endcase
  end

  assign bus.ready = completion;
  assign bus.rdata = completion ? rd_val : 32'd0;
  assign irqTimer  = irq_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      wait_cnt_q <= '0;
      off_q      <= '0;
      wr_q       <= 1'b0;
      wdata_q    <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.select && !bus.enable) begin
            off_q      <= bus.addr[4:2];
            wr_q       <= bus.write;
            wdata_q    <= bus.wdata;
            wait_cnt_q <= WAIT_INIT;
            state_q    <= WAIT;
          end
        end
        WAIT: begin
          if (!bus.select) begin
            state_q <= IDLE;
          end else if (bus.enable) begin
            if (wait_cnt_q == 4'd0) begin
              state_q <= IDLE;
            end else begin
              wait_cnt_q <= wait_cnt_q - 4'd1;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mtime_q    <= '0;
      mtimecmp_q <= '1;
      run_q      <= 1'b0;
      irq_en_q   <= 1'b0;
      div_q      <= '0;
      pcnt_q     <= '0;
      shadow_q   <= '0;
      irq_q      <= 1'b0;
    end else begin
      irq_q   <= irq_en_q && mtime_ge;
      mtime_q <= mtime_ticked;
      if (run_q) begin
        pcnt_q <= tick ? '0 : pcnt_q + 1'b1;
      end
      if (do_read_lo) begin
        shadow_q <= mtime_q[63:32];
      end
      // A written mtime half wins over the tick; carry out of a written lo is dropped.
      if (do_write) begin
        case (off_q)
          3'd0: mtime_q <= {mtime_q[63:32], wdata_q};
          3'd1: mtime_q <= {wdata_q, mtime_ticked[31:0]};
          3'd2: mtimecmp_q[31:0]  <= wdata_q;
          3'd3: mtimecmp_q[63:32] <= wdata_q;
          3'd4: begin
            run_q    <= wdata_q[0];
            irq_en_q <= wdata_q[1];
            div_q    <= wdata_q[8 +: PRESCALE_WIDTH];
            pcnt_q   <= '0;
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: doc/bus_timer.md
Name: bus_timer

Overview:
- Machine-timer peripheral that sits directly downstream of the core on its APB-like bus.
- Consumes core transactions (addr/select/enable/write/wdata) and returns rdata/ready.
- Produces the core's irqTimer input.
- Holds a 64-bit mtime counter with programmable prescaler, a 64-bit mtimecmp, and a control register; the interconnect drives select only for this block's address window.

Parameters:
- WAIT_CYCLES, 0, access-phase wait states inserted before ready; 0..15.
- PRESCALE_WIDTH, 8, width of prescaler divisor field and counter.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous, active-low reset
- addr  in  32  byte address; only addr[4:2] decoded
- select  in  1  block selected (setup and access phases)
- enable  in  1  access phase
- write  in  1  1 = write, 0 = read
- wdata  in  32  write data
- rdata  out  32  read data, valid only while ready=1
- ready  out  1  transfer completes this cycle
- irqTimer  out  1  timer interrupt request, level

Behaviour:
- Reset (rst=0, async): mtime=0, mtimecmp=64'hFFFF_FFFF_FFFF_FFFF, ctrl=0, prescale count=0, hi shadow=0, FSM=IDLE, ready=0, rdata=0, irqTimer=0.
- Register map (addr[4:2]):
  - 0 = mtime[31:0]
  - 1 = mtime[63:32]
  - 2 = mtimecmp[31:0]
  - 3 = mtimecmp[63:32]
  - 4 = ctrl: bit0 run, bit1 irqEn, bits[8+PRESCALE_WIDTH-1:8] div
  - 5 = status: bit0 = (mtime >= mtimecmp), read-only
  - 6,7 = read 0, writes ignored, still complete with ready
- FSM:
  - IDLE: select=1 & enable=0 -> SETUP. enable=1 without a prior setup cycle is ignored and stays IDLE.
  - SETUP: latch addr[4:2], write, wdata; go to WAIT (wait count = WAIT_CYCLES).
  - WAIT: requires select=1 & enable=1. If the count is 0, this is the completion cycle; otherwise decrement.
  - Completion cycle: ready=1 for exactly one cycle, rdata driven, write committed at the clock edge ending the cycle; then IDLE.
  - Latency: with WAIT_CYCLES=0, ready rises in the first enable cycle; each wait state adds one cycle.
  - select dropping in WAIT aborts to IDLE: no write, no ready.
- rdata is combinational from registers during the completion cycle, and 0 otherwise.
- Consistent 64-bit read: reading offset 0 copies mtime[63:32] into the hi shadow in that same cycle. Reading offset 1 returns the shadow, not live mtime[63:32]. Writing offset 0 or 1 does not update the shadow.
- Counting:
  - When ctrl.run=1, the prescale count increments each cycle.
  - When count == div, count goes to 0 and mtime += 1, wrapping 2^64-1 -> 0.
  - div=0 means mtime increments every cycle.
  - ctrl.run=0 freezes both mtime and the prescale count.
  - A ctrl write resets the prescale count to 0.
- Write to mtime lo/hi in the same cycle as a tick: the written half takes wdata, the other half takes its ticked value (carry out of lo is discarded if lo is written).
- irqTimer is registered: irqTimer(next) = irqEn & (mtime >= mtimecmp), unsigned 64-bit compare, evaluated on the current register values. This gives one cycle of latency after the compare becomes true. It deasserts one cycle after mtimecmp is raised or irqEn is cleared.
- Writing mtimecmp halves independently is permitted; glitches are software's responsibility.
- Reset mid-transaction: immediately returns to the reset state; the pending write is lost and ready=0.

Test Plan:
- Reset, then read offset 4 (WAIT_CYCLES=0) -> ready=1 on the first enable cycle, rdata=0; irqTimer=0 throughout.
- Write ctrl=0x0000_0301 (run, div=3), idle 40 cycles, read offset 0 -> rdata=10 (±1 depending on sample point); ticks occur every 4 cycles.
- Write mtime lo=0xFFFF_FFFF, hi=0, ctrl div=0 run=1, read offset 0 then 1 -> hi returns the shadow latched at the lo read (0 or 1, matching the lo value), never torn.
- mtimecmp={0,20}, ctrl irqEn|run div=0 from mtime=0 -> irqTimer rises exactly one cycle after mtime reaches 20; write mtimecmp lo=0xFFFF_FFFF -> irqTimer falls one cycle after the write completes.
- WAIT_CYCLES=3, write offset 2 -> ready asserts on the 4th enable cycle; drop select after 2 enable cycles -> no ready, mtimecmp unchanged.
- Assert rst low during the WAIT state of a write to offset 3 -> ready=0, mtimecmp=all ones after release; enable pulse without setup -> no ready.
